tia_audio_bank: RTL and testbench

Parametrised TIA sound generator holding CHANNELS independent tone/noise channels, each with its own AUDC/AUDF/AUDV registers, 5-bit frequency divider, 4-bit pulse counter and 5-bit noise counter. It is clocked by the two per-scanline audio strobes from the horizontal counter (aud0, aud1) and produces per-channel 4-bit samples plus a registered unsigned sum. The block sits beside the TIA register file. The register file forwards AUDCx/AUDFx/AUDVx writes through the write port. The mix output feeds the platform audio path.

---
 rtl/tia_audio_bank_if.sv | 18 +
 rtl/tia_audio_bank.sv | 160 ++++++++++++++++
 tb/tb_tia_audio_bank.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/tia_audio_bank_if.sv
// Register write port and sample outputs of the TIA audio bank.
interface tia_audio_bank_if #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned MIX_W    = 4 + $clog2(CHANNELS)
);
  localparam int unsigned WCH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                    we;
  logic [WCH_W-1:0]        wch;
  logic [1:0]              wreg;
  logic [7:0]              wdata;
  logic [4*CHANNELS-1:0]   ch_out;
  logic [MIX_W-1:0]        mix;
  logic                    mix_valid;

  modport master (output we, wch, wreg, wdata, input ch_out, mix, mix_valid);
  modport slave  (input we, wch, wreg, wdata, output ch_out, mix, mix_valid);
endinterface

// File: rtl/tia_audio_bank.sv
// Bank of TIA tone/noise channels stepped by the two per-scanline audio strobes,
// with per-channel 4-bit samples and a registered full-width mix.
module tia_audio_bank #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned MIX_W    = 4 + $clog2(CHANNELS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            aud0,
  input  logic            aud1,
  tia_audio_bank_if.slave bus
);

  logic [3:0] audc_q  [CHANNELS];
  logic [3:0] audc_d  [CHANNELS];
  logic [4:0] audf_q  [CHANNELS];
  logic [4:0] audf_d  [CHANNELS];
  logic [3:0] audv_q  [CHANNELS];
  logic [3:0] audv_d  [CHANNELS];
  logic [4:0] div_q   [CHANNELS];
  logic [4:0] div_d   [CHANNELS];
  logic [3:0] pulse_q [CHANNELS];
  logic [3:0] pulse_d [CHANNELS];
  logic [4:0] noise_q [CHANNELS];
  logic [4:0] noise_d [CHANNELS];

  logic [CHANNELS-1:0] clk_en_q, clk_en_d;
  logic [CHANNELS-1:0] hold_q,   hold_d;
  logic [CHANNELS-1:0] nfb_q,    nfb_d;

  logic                  aud1_q, aud1_d;
  logic [MIX_W-1:0]      mix_q, mix_d;
  logic                  mix_valid_q, mix_valid_d;
  logic [4*CHANNELS-1:0] ch_out_c;
  logic [MIX_W-1:0]      sum_c;
  logic                  unused_wdata;

  assign unused_wdata = ^bus.wdata[7:5];

  function automatic logic hold_fn(input logic [3:0] c, input logic [4:0] nz);
    case (c[1:0])
      2'd2:    return nz[4:1] != 4'b0001;
      2'd3:    return ~nz[0];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic nfb_fn(input logic [3:0] c, input logic [3:0] p,
                                  input logic [4:0] nz);
    if (c[1:0] == 2'd0)
      return (p[0] ^ nz[0]) | ~((nz != 5'd0) | (p != 4'hA)) | (c[3:2] == 2'd0);
    else
      return (nz[2] ^ nz[0]) | (nz == 5'd0);
  endfunction

  function automatic logic pfb_fn(input logic [3:0] c, input logic [3:0] p,
                                  input logic [4:0] nz);
    case (c[3:2])
      2'd0:    return (p[1] ^ p[0]) & (p != 4'hA) & (|c[1:0]);
      2'd1:    return ~p[3];
      2'd2:    return ~nz[0];
      default: return ~(p[1] | ~|p[3:1]);
    endcase
  endfunction

  // Per-channel next state: register writes, phase-0 divider/latches, phase-1 shift.
  always_comb begin
    clk_en_d = clk_en_q;
    hold_d   = hold_q;
    nfb_d    = nfb_q;
    ch_out_c = '0;
    for (int unsigned n = 0; n < CHANNELS; n++) begin
      audc_d[n]  = audc_q[n];
      audf_d[n]  = audf_q[n];
      audv_d[n]  = audv_q[n];
      div_d[n]   = div_q[n];
      pulse_d[n] = pulse_q[n];
      noise_d[n] = noise_q[n];

      if (bus.we && (32'(bus.wch) == n)) begin
        case (bus.wreg)
          2'd0:    audc_d[n] = bus.wdata[3:0];
          2'd1:    audf_d[n] = bus.wdata[4:0];
          2'd2:    audv_d[n] = bus.wdata[3:0];
          default: ;
        endcase
      end

      if (aud0) begin
        if (div_q[n] >= audf_q[n]) begin
          div_d[n]    = 5'd0;
          clk_en_d[n] = 1'b1;
        end else begin
          div_d[n]    = div_q[n] + 5'd1;
          clk_en_d[n] = 1'b0;
        end
        hold_d[n] = hold_fn(audc_q[n], noise_q[n]);
        nfb_d[n]  = nfb_fn(audc_q[n], pulse_q[n], noise_q[n]);
      end

      // Phase 1 consumes the pre-cycle enable/hold/feedback even when aud0 coincides.
      if (aud1 && clk_en_q[n]) begin
        noise_d[n] = {nfb_q[n], noise_q[n][4:1]};
        if (!hold_q[n])
          pulse_d[n] = {pfb_fn(audc_q[n], pulse_q[n], noise_q[n]), ~pulse_q[n][3:1]};
      end

      ch_out_c[4*n +: 4] = pulse_q[n][0] ? audv_q[n] : 4'd0;
    end
  end

  // Mix is taken the clk after aud1 so it reflects post-phase-1 pulses.
  always_comb begin
    sum_c = '0;
    for (int unsigned n = 0; n < CHANNELS; n++)
      sum_c = sum_c + MIX_W'(ch_out_c[4*n +: 4]);
    aud1_d      = aud1;
    mix_valid_d = aud1_q;
    mix_d       = aud1_q ? sum_c : mix_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned n = 0; n < CHANNELS; n++) begin
        audc_q[n]  <= 4'd0;
        audf_q[n]  <= 5'd0;
        audv_q[n]  <= 4'd0;
        div_q[n]   <= 5'd0;
        pulse_q[n] <= 4'd0;
        noise_q[n] <= 5'd0;
      end
      clk_en_q    <= '0;
      hold_q      <= '0;
      nfb_q       <= '0;
      aud1_q      <= 1'b0;
      mix_q       <= '0;
      mix_valid_q <= 1'b0;
    end else begin
      for (int unsigned n = 0; n < CHANNELS; n++) begin
        audc_q[n]  <= audc_d[n];
        audf_q[n]  <= audf_d[n];
        audv_q[n]  <= audv_d[n];
        div_q[n]   <= div_d[n];
        pulse_q[n] <= pulse_d[n];
        noise_q[n] <= noise_d[n];
      end
      clk_en_q    <= clk_en_d;
      hold_q      <= hold_d;
      nfb_q       <= nfb_d;
      aud1_q      <= aud1_d;
      mix_q       <= mix_d;
      mix_valid_q <= mix_valid_d;
    end
  end

  assign bus.ch_out    = ch_out_c;
  assign bus.mix       = mix_q;
  assign bus.mix_valid = mix_valid_q;

endmodule

// File: tb/tb_tia_audio_bank.sv
// Directed bench for tia_audio_bank: a 2-channel and a 3-channel instance share clk/reset/strobes.
module tb_tia_audio_bank;

  logic clk;
  logic reset;
  logic aud0;
  logic aud1;

  int n_vec = 0;
  int n_bad = 0;

  tia_audio_bank_if #(.CHANNELS(2)) bus_a ();
  tia_audio_bank_if #(.CHANNELS(3)) bus_b ();

  tia_audio_bank #(.CHANNELS(2)) dut_a (
    .clk(clk), .reset(reset), .aud0(aud0), .aud1(aud1), .bus(bus_a)
  );
  tia_audio_bank #(.CHANNELS(3)) dut_b (
    .clk(clk), .reset(reset), .aud0(aud0), .aud1(aud1), .bus(bus_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_a(input int ch, input logic [1:0] r, input logic [7:0] d);
    bus_a.wch = 1'(ch); bus_a.wreg = r; bus_a.wdata = d; bus_a.we = 1'b1;
    tick();
    bus_a.we = 1'b0;
  endtask

  task automatic wr_b(input int ch, input logic [1:0] r, input logic [7:0] d);
    bus_b.wch = 2'(ch); bus_b.wreg = r; bus_b.wdata = d; bus_b.we = 1'b1;
    tick();
    bus_b.we = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // One scanline: aud0, gap, aud1; then check ch0, mix and the mix_valid pulse.
  task automatic line_chk(input string tag, input int exp_ch0, input int exp_mix);
    aud0 = 1'b1; tick(); aud0 = 1'b0;
    tick();
    aud1 = 1'b1; tick(); aud1 = 1'b0;
    chk({tag, ".ch0"}, 32'(bus_a.ch_out[3:0]), 32'(exp_ch0));
    chk({tag, ".vlo"}, 32'(bus_a.mix_valid), 32'd0);
    tick();
    chk({tag, ".mix"}, 32'(bus_a.mix), 32'(exp_mix));
    chk({tag, ".vhi"}, 32'(bus_a.mix_valid), 32'd1);
    tick();
    chk({tag, ".vend"}, 32'(bus_a.mix_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; aud0 = 1'b0; aud1 = 1'b0;
    bus_a.we = 1'b0; bus_a.wch = '0; bus_a.wreg = '0; bus_a.wdata = '0;
    bus_b.we = 1'b0; bus_b.wch = '0; bus_b.wreg = '0; bus_b.wdata = '0;
    tick(); tick();
    chk("rst.ch_a", 32'(bus_a.ch_out), 32'd0);
    chk("rst.mix_a", 32'(bus_a.mix), 32'd0);
    chk("rst.mv_a", 32'(bus_a.mix_valid), 32'd0);
    chk("rst.ch_b", 32'(bus_b.ch_out), 32'd0);
    chk("rst.mix_b", 32'(bus_b.mix), 32'd0);
    reset = 1'b0;

    // Get some non-zero state, then reset while strobes and writes are active.
    wr_a(0, 2'd0, 8'h04); wr_a(0, 2'd1, 8'h00); wr_a(0, 2'd2, 8'h0F);
    line_chk("pre", 15, 15);
    reset = 1'b1; aud0 = 1'b1; aud1 = 1'b1;
    bus_a.we = 1'b1; bus_a.wch = 1'b0; bus_a.wreg = 2'd2; bus_a.wdata = 8'h0F;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rsth.ch", 32'(bus_a.ch_out), 32'd0);
      chk("rsth.mix", 32'(bus_a.mix), 32'd0);
      chk("rsth.mv", 32'(bus_a.mix_valid), 32'd0);
    end
    reset = 1'b0; aud0 = 1'b0; aud1 = 1'b0; bus_a.we = 1'b0;
    tick();
    chk("rstr.ch", 32'(bus_a.ch_out), 32'd0);
    chk("rstr.mix", 32'(bus_a.mix), 32'd0);
    chk("rstr.mv", 32'(bus_a.mix_valid), 32'd0);

    // Pure tone: pulse 0->F->0 each line.
    wr_a(0, 2'd0, 8'h04); wr_a(0, 2'd1, 8'h00); wr_a(0, 2'd2, 8'h0F);
    line_chk("tone1", 15, 15);
    line_chk("tone2", 0, 0);
    line_chk("tone3", 15, 15);
    line_chk("tone4", 0, 0);

    // Divide by 3.
    do_reset();
    wr_a(0, 2'd0, 8'h04); wr_a(0, 2'd1, 8'h02); wr_a(0, 2'd2, 8'h0F);
    line_chk("div1", 0, 0);
    line_chk("div2", 0, 0);
    line_chk("div3", 15, 15);
    line_chk("div4", 15, 15);
    line_chk("div5", 15, 15);
    line_chk("div6", 0, 0);

    // DC mode: pulse 0->7->4->5->5.
    do_reset();
    wr_a(0, 2'd0, 8'h00); wr_a(0, 2'd1, 8'h00); wr_a(0, 2'd2, 8'h07);
    line_chk("dc1", 7, 7);
    line_chk("dc2", 0, 0);
    line_chk("dc3", 7, 7);
    line_chk("dc4", 7, 7);
    line_chk("dc5", 7, 7);

    // AUDF lowered below a running divider.
    do_reset();
    wr_a(0, 2'd0, 8'h04); wr_a(0, 2'd1, 8'h1F); wr_a(0, 2'd2, 8'h0F);
    for (int i = 0; i < 10; i++) line_chk("lowpre", 0, 0);
    wr_a(0, 2'd1, 8'h02);
    line_chk("low1", 15, 15);
    line_chk("low2", 15, 15);

    // Two-channel mix: ch0 tone V=15, ch1 DC V=7.
    do_reset();
    wr_a(0, 2'd0, 8'h04); wr_a(0, 2'd1, 8'h00); wr_a(0, 2'd2, 8'h0F);
    wr_a(1, 2'd0, 8'h00); wr_a(1, 2'd1, 8'h00); wr_a(1, 2'd2, 8'h07);
    line_chk("mix1", 15, 22);
    line_chk("mix2", 0, 0);
    line_chk("mix3", 15, 22);
    line_chk("mix4", 0, 7);
    line_chk("mix5", 15, 22);
    line_chk("mix6", 0, 7);

    // AUDV write to ch1 coincident with aud1.
    aud0 = 1'b1; tick(); aud0 = 1'b0; tick();
    aud1 = 1'b1;
    bus_a.we = 1'b1; bus_a.wch = 1'b1; bus_a.wreg = 2'd2; bus_a.wdata = 8'h03;
    tick();
    aud1 = 1'b0; bus_a.we = 1'b0;
    chk("wa1.ch", 32'(bus_a.ch_out), 32'h3F);
    tick();
    chk("wa1.mix", 32'(bus_a.mix), 32'd18);
    chk("wa1.mv", 32'(bus_a.mix_valid), 32'd1);
    tick();

    // AUDF write coincident with aud0: divider still compares against the old AUDF=0.
    aud0 = 1'b1;
    bus_a.we = 1'b1; bus_a.wch = 1'b0; bus_a.wreg = 2'd1; bus_a.wdata = 8'h05;
    tick();
    aud0 = 1'b0; bus_a.we = 1'b0;
    tick();
    aud1 = 1'b1; tick(); aud1 = 1'b0;
    chk("wa0.ch", 32'(bus_a.ch_out), 32'h30);
    tick();
    chk("wa0.mix", 32'(bus_a.mix), 32'd3);
    tick();
    wr_a(0, 2'd1, 8'h00);
    line_chk("wa0.nxt", 15, 18);

    // Coincident aud0/aud1: phase 1 sees the pre-cycle clk_en.
    do_reset();
    wr_a(0, 2'd0, 8'h04); wr_a(0, 2'd1, 8'h01); wr_a(0, 2'd2, 8'h0F);
    line_chk("co1", 0, 0);
    aud0 = 1'b1; aud1 = 1'b1; tick(); aud0 = 1'b0; aud1 = 1'b0;
    chk("co.ch", 32'(bus_a.ch_out[3:0]), 32'd0);
    tick();
    chk("co.mv", 32'(bus_a.mix_valid), 32'd1);
    chk("co.mix", 32'(bus_a.mix), 32'd0);
    tick();
    aud1 = 1'b1; tick(); aud1 = 1'b0;
    chk("co2.ch", 32'(bus_a.ch_out[3:0]), 32'd15);
    tick();
    chk("co2.mix", 32'(bus_a.mix), 32'd15);
    tick();

    // Three channels: writes with wch=3 are ignored.
    do_reset();
    wr_b(2, 2'd0, 8'h04); wr_b(2, 2'd2, 8'h09);
    wr_b(3, 2'd2, 8'h05); wr_b(3, 2'd0, 8'h04);
    line_chk("b1", 0, 0);
    chk("b1.ch", 32'(bus_b.ch_out), 32'h900);
    chk("b1.mix", 32'(bus_b.mix), 32'd9);
    wr_b(3, 2'd2, 8'h01);
    line_chk("b2", 0, 0);
    chk("b2.ch", 32'(bus_b.ch_out), 32'h000);
    chk("b2.mix", 32'(bus_b.mix), 32'd0);
    line_chk("b3", 0, 0);
    chk("b3.ch", 32'(bus_b.ch_out), 32'h900);
    chk("b3.mix", 32'(bus_b.mix), 32'd9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
